// File: rtl/pci_pkg.sv
// Shared PCI definitions: bus command codes and the target state encoding.
// Imported by pci_mem_target and intended for the matching initiator.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'h6;
    localparam logic [3:0] CMD_MEM_WRITE = 4'h7;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_WAIT_ENC = 3'd1;
    localparam logic [2:0] ST_DATA_ENC = 3'd2;
    localparam logic [2:0] ST_DISC_ENC = 3'd3;
    localparam logic [2:0] ST_TURN_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_DISC = ST_DISC_ENC,
        ST_TURN = ST_TURN_ENC
    } state_e;

endpackage

// File: rtl/pci_mem_target_if.sv
// PCI target pin bundle in split-tristate form: each bidirectional pin is an
// input sample, an output value and an output enable; the pad ring resolves z.
//  ad_in/cbe_n/frame_n/irdy_n : driven by the initiator (master)
//  ad_out/ad_oe               : read data and its enable (oe=0 means AD is z)
//  trdy_n/devsel_n/stop_n     : target control, all enabled by ctl_oe
interface pci_mem_target_if;
    logic [31:0] ad_in;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic [3:0]  cbe_n;
    logic        frame_n;
    logic        irdy_n;
    logic        trdy_n;
    logic        devsel_n;
    logic        stop_n;
    logic        ctl_oe;

    modport slave (
        input  ad_in, cbe_n, frame_n, irdy_n,
        output ad_out, ad_oe, trdy_n, devsel_n, stop_n, ctl_oe
    );

    modport master (
        output ad_in, cbe_n, frame_n, irdy_n,
        input  ad_out, ad_oe, trdy_n, devsel_n, stop_n, ctl_oe
    );
endinterface

// File: rtl/pci_target_ram.sv
// DEPTH x 32 storage for the target window: per-byte write enables on the
// clock edge, asynchronous read. Contents are not affected by reset.
//  i_clk, i_we[3:0] (lane enables), i_addr, i_wdata, o_rdata
module pci_target_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pci_mem_target.sv
// PCI memory target: one DEPTH-word window at BASE_ADDR, single and burst
// memory read/write with byte enables, programmable initial wait states,
// target disconnect at the window end and a one-clock turnaround.
//  CLK, RST (async, active-low), bus (slave modport), BUSY (hit until release)
module pci_mem_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    pci_mem_target_if.slave      bus,
    output logic                 BUSY
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [2:0]    WS_LOAD  = 3'(WAIT_STATES - 1);

    state_e        r_state;
    logic          r_frame_prev;
    logic [AW-1:0] r_idx;
    logic          r_rd;
    logic [2:0]    r_cnt;
    logic          r_ctl_oe;
    logic          r_trdy_n;
    logic          r_devsel_n;
    logic          r_stop_n;
    logic          r_ad_oe;
    logic          r_busy;

    logic          w_addr_phase;
    logic          w_win;
    logic          w_cmd_ok;
    logic          w_hit;
    logic          w_xfer;
    logic          w_abort;
    logic [3:0]    w_we;
    logic [31:0]   w_rdata;

    // Address phase is the first edge of FRAME low.
    assign w_addr_phase = r_frame_prev & ~bus.frame_n;
    assign w_win    = (bus.ad_in >> (AW + 2)) == (BASE_ADDR >> (AW + 2));
    assign w_cmd_ok = (bus.cbe_n == CMD_MEM_READ) ||
                      (bus.cbe_n == CMD_MEM_WRITE);
    assign w_hit    = w_addr_phase && w_win &&
                      (bus.ad_in[1:0] == 2'b00) && w_cmd_ok;

    // TRDY is held low for the whole of DATA, so IRDY alone qualifies it.
    assign w_xfer  = (r_state == ST_DATA) && !bus.irdy_n;
    assign w_abort = bus.frame_n && bus.irdy_n;
    assign w_we    = (w_xfer && !r_rd) ? ~bus.cbe_n : 4'h0;

    pci_target_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_wdata (bus.ad_in),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_frame_prev <= 1'b1;
            r_idx        <= '0;
            r_rd         <= 1'b0;
            r_cnt        <= '0;
            r_ctl_oe     <= 1'b0;
            r_trdy_n     <= 1'b1;
            r_devsel_n   <= 1'b1;
            r_stop_n     <= 1'b1;
            r_ad_oe      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_prev <= bus.frame_n;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state    <= ST_WAIT;
                        r_idx      <= bus.ad_in[AW+1:2];
                        r_rd       <= (bus.cbe_n == CMD_MEM_READ);
                        r_cnt      <= WS_LOAD;
                        r_ctl_oe   <= 1'b1;
                        r_devsel_n <= 1'b0;
                        r_trdy_n   <= 1'b1;
                        r_stop_n   <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_abort) begin
                        r_state    <= ST_TURN;
                        r_devsel_n <= 1'b1;
                    end else if (r_cnt == 3'd0) begin
                        r_state  <= ST_DATA;
                        r_trdy_n <= 1'b0;
                        // Earliest entry is one clock after the address
                        // phase, which gives reads their turnaround clock.
                        r_ad_oe  <= r_rd;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + AW'(1);
                        if (bus.frame_n) begin
                            r_state    <= ST_TURN;
                            r_trdy_n   <= 1'b1;
                            r_devsel_n <= 1'b1;
                            r_ad_oe    <= 1'b0;
                        end else if (r_idx == IDX_LAST) begin
                            // No wrap: stop the initiator at the window end.
                            r_state  <= ST_DISC;
                            r_trdy_n <= 1'b1;
                            r_stop_n <= 1'b0;
                            r_ad_oe  <= 1'b0;
                        end
                    end else if (w_abort) begin
                        r_state    <= ST_TURN;
                        r_trdy_n   <= 1'b1;
                        r_devsel_n <= 1'b1;
                        r_ad_oe    <= 1'b0;
                    end
                end
                ST_DISC: begin
                    if (bus.frame_n) begin
                        r_state    <= ST_TURN;
                        r_devsel_n <= 1'b1;
                        r_stop_n   <= 1'b1;
                    end
                end
                ST_TURN: begin
                    r_state  <= ST_IDLE;
                    r_ctl_oe <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ctl_oe <= 1'b0;
                    r_ad_oe  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ad_out   = w_rdata;
    assign bus.ad_oe    = r_ad_oe;
    assign bus.ctl_oe   = r_ctl_oe;
    assign bus.trdy_n   = r_trdy_n;
    assign bus.devsel_n = r_devsel_n;
    assign bus.stop_n   = r_stop_n;
    assign BUSY         = r_busy;

endmodule
